// File: rtl/kmp_lps_builder.sv
// Builds the KMP prefix (LPS / failure) table for a pattern in sync-read RAM.
// Optional `KMP_LPS_STATS_EN` adds a saturating COMPARE-cycle counter output.
module kmp_lps_builder #(
    parameter int PAT_AW = 4,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAT_AW:0]   pat_len,
    output logic [PAT_AW-1:0] pat_addr,
    input  logic [DW-1:0]     pat_data,
    output logic [PAT_AW-1:0] lps_raddr,
    input  logic [PAT_AW:0]   lps_rdata,
    output logic              lps_we,
    output logic [PAT_AW-1:0] lps_waddr,
    output logic [PAT_AW:0]   lps_wdata,
    output logic              busy,
    output logic              done,
    output logic              len_err
`ifdef KMP_LPS_STATS_EN
    ,
    output logic [15:0]       cmp_count
`endif
);

    typedef enum logic [3:0] {
        IDLE, INIT, FETCH_I, CAPT, COMPARE, FALLBACK, LOAD, REFETCH, DONE
    } state_t;

    localparam logic [PAT_AW:0] ZERO    = '0;
    localparam logic [PAT_AW:0] ONE     = {{PAT_AW{1'b0}}, 1'b1};
    localparam logic [PAT_AW:0] MAX_LEN = {1'b1, {PAT_AW{1'b0}}};

    state_t            state, state_nx;
    logic [PAT_AW:0]   i, len, m;
    logic [DW-1:0]     ci;
    logic              eq, bad_len;
    logic [PAT_AW:0]   i_inc, len_inc, len_dec;

    assign eq      = (ci == pat_data);
    assign i_inc   = i + ONE;
    assign len_inc = len + ONE;
    assign len_dec = len - ONE;
    assign bad_len = (pat_len == ZERO) || (pat_len > MAX_LEN);

    always_comb begin
        state_nx  = state;
        pat_addr  = '0;
        lps_raddr = '0;
        lps_we    = 1'b0;
        lps_waddr = '0;
        lps_wdata = '0;
        done      = 1'b0;
        busy      = (state != IDLE) && (state != DONE);
        case (state)
            IDLE: begin
                if (start) state_nx = bad_len ? DONE : INIT;
            end
            INIT: begin
                lps_we   = 1'b1;
                state_nx = (m == ONE) ? DONE : FETCH_I;
            end
            FETCH_I: begin
                pat_addr = i[PAT_AW-1:0];
                state_nx = CAPT;
            end
            CAPT: begin
                pat_addr = len[PAT_AW-1:0];
                state_nx = COMPARE;
            end
            COMPARE: begin
                // A mismatch with a nonzero prefix falls back instead of writing.
                if (eq || len == ZERO) begin
                    lps_we    = 1'b1;
                    lps_waddr = i[PAT_AW-1:0];
                    lps_wdata = eq ? len_inc : ZERO;
                    state_nx  = (i_inc == m) ? DONE : FETCH_I;
                end else begin
                    state_nx = FALLBACK;
                end
            end
            FALLBACK: begin
                lps_raddr = len_dec[PAT_AW-1:0];
                state_nx  = LOAD;
            end
            LOAD:    state_nx = REFETCH;
            REFETCH: begin
                pat_addr = len[PAT_AW-1:0];
                state_nx = COMPARE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            i       <= '0;
            len     <= '0;
            m       <= '0;
            ci      <= '0;
            len_err <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    m       <= pat_len;
                    len_err <= bad_len;
                end
                INIT: begin
                    i   <= ONE;
                    len <= ZERO;
                end
                CAPT: ci <= pat_data;
                COMPARE: begin
                    if (eq) begin
                        len <= len_inc;
                        i   <= i_inc;
                    end else if (len == ZERO) begin
                        i <= i_inc;
                    end
                end
                LOAD: len <= lps_rdata;
                default: ;
            endcase
        end
    end

`ifdef KMP_LPS_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || (state == IDLE && start)) cmp_count <= '0;
        else if (state == COMPARE && cmp_count != 16'hFFFF) cmp_count <= cmp_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_kmp_lps_builder.sv
// Self-checking bench for kmp_lps_builder: vector table, reset/abort sequence,
// and random patterns against a textbook KMP prefix-function model.
module tb_kmp_lps_builder;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   pat_len = '0;
    logic [AW-1:0] pat_addr, lps_raddr, lps_waddr;
    logic [DW-1:0] pat_data;
    logic [AW:0]   lps_rdata, lps_wdata;
    logic          lps_we, busy, done, len_err;
`ifdef KMP_LPS_STATS_EN
    logic [15:0]   cmp_count;
`endif

    kmp_lps_builder #(.PAT_AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_len(pat_len),
        .pat_addr(pat_addr), .pat_data(pat_data),
        .lps_raddr(lps_raddr), .lps_rdata(lps_rdata),
        .lps_we(lps_we), .lps_waddr(lps_waddr), .lps_wdata(lps_wdata),
        .busy(busy), .done(done), .len_err(len_err)
`ifdef KMP_LPS_STATS_EN
        , .cmp_count(cmp_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read pattern and table RAMs
    logic [DW-1:0] pat_mem [16];
    logic [AW:0]   lps_mem [16];
    logic          clr_lps = 1'b0;
    always @(posedge clk) begin
        pat_data  <= pat_mem[pat_addr];
        lps_rdata <= lps_mem[lps_raddr];
        if (clr_lps) begin
            for (int k = 0; k < 16; k++) lps_mem[k] <= '1;
        end else if (lps_we) begin
            lps_mem[lps_waddr] <= lps_wdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: classic prefix-function loop, also counting fallbacks.
    int mdl_t [16];
    int mdl_f;
    function automatic void ref_lps(input string p);
        int ln, ix;
        ln = 0; ix = 1; mdl_f = 0;
        for (int k = 0; k < 16; k++) mdl_t[k] = 0;
        while (ix < p.len()) begin
            if (p[ix] == p[ln]) begin
                ln++; mdl_t[ix] = ln; ix++;
            end else if (ln != 0) begin
                ln = mdl_t[ln-1]; mdl_f++;
            end else begin
                mdl_t[ix] = 0; ix++;
            end
        end
    endfunction

    int exp_t [16];

    task automatic load(input string p);
        for (int k = 0; k < 16; k++) pat_mem[k] = (k < p.len()) ? p[k] : 8'h00;
        @(negedge clk); clr_lps = 1'b1;
        @(negedge clk); clr_lps = 1'b0;
    endtask

    task automatic run(input string nm, input string p, input int m,
                       input int exp_done, input bit exp_err, input bit poke);
        int c, done_at, dones, busy_cyc, we_cnt, err_at_done;
        load(p);
        pat_len = m[AW:0];
        start   = 1'b1;
        @(posedge clk);
        c = 0; done_at = -1; dones = 0; busy_cyc = 0; we_cnt = 0; err_at_done = -1;
        while (c < 300 && !(done_at >= 0 && c >= done_at + 2)) begin
            @(negedge clk);
            c++;
            start   = poke && c >= 3 && c <= 6;
            pat_len = (poke && start) ? 5'd3 : m[AW:0];
            if (done) begin
                dones++;
                if (done_at < 0) begin done_at = c; err_at_done = len_err; end
            end
            if (busy)   busy_cyc++;
            if (lps_we) we_cnt++;
        end
        start = 1'b0;
        chk({nm, " done_cycle"}, done_at, exp_done);
        chk({nm, " done_pulses"}, dones, 1);
        chk({nm, " busy_cycles"}, busy_cyc, exp_done - 1);
        chk({nm, " len_err_at_done"}, err_at_done, int'(exp_err));
        chk({nm, " len_err_sticky"}, int'(len_err), int'(exp_err));
        chk({nm, " writes"}, we_cnt, exp_err ? 0 : m);
        if (!exp_err)
            for (int k = 0; k < m; k++)
                chk($sformatf("%s lps[%0d]", nm, k), int'(lps_mem[k]), exp_t[k]);
`ifdef KMP_LPS_STATS_EN
        chk({nm, " cmp_count"}, int'(cmp_count),
            exp_err ? 0 : (m - 1) + (exp_done - 2 - 3 * (m - 1)) / 4);
`endif
    endtask

    typedef struct {
        string nm;
        string p;
        int    m;
        string tab;
        int    dcyc;
        bit    err;
        bit    poke;
    } vec_t;

    vec_t v [9];

    initial begin
        v[0] = '{"aabaac",    "AABAACAABAA", 11, "01012012345", 44, 1'b0, 1'b0};
        v[1] = '{"abcd",      "ABCD",         4, "0000",        11, 1'b0, 1'b0};
        v[2] = '{"aaaa",      "AAAA",         4, "0123",        11, 1'b0, 1'b0};
        v[3] = '{"abab",      "ABAB",         4, "0012",        11, 1'b0, 1'b0};
        v[4] = '{"len0",      "AB",           0, "",             1, 1'b1, 1'b0};
        v[5] = '{"len17",     "AB",          17, "",             1, 1'b1, 1'b0};
        v[6] = '{"after_err", "ABAB",         4, "0012",        11, 1'b0, 1'b0};
        v[7] = '{"poke",      "AABAACAABAA", 11, "01012012345", 44, 1'b0, 1'b1};
        v[8] = '{"single",    "A",            1, "0",            2, 1'b0, 1'b0};

        for (int k = 0; k < 16; k++) pat_mem[k] = 8'h00;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst len_err", int'(len_err), 0);
        chk("rst lps_we", int'(lps_we), 0);
        chk("rst addrs", int'(pat_addr) + int'(lps_raddr) + int'(lps_waddr) + int'(lps_wdata), 0);
`ifdef KMP_LPS_STATS_EN
        chk("rst cmp_count", int'(cmp_count), 0);
`endif
        rst = 1'b1;

        for (int n = 0; n < 9; n++) begin
            for (int k = 0; k < 16; k++)
                exp_t[k] = (k < v[n].tab.len()) ? int'(v[n].tab[k]) - 48 : 0;
            run(v[n].nm, v[n].p, v[n].m, v[n].dcyc, v[n].err, v[n].poke);
        end

        // Reset during the first COMPARE (cycle 4), then a clean rebuild
        begin
            int dn;
            load("AABAACAABAA");
            pat_len = 5'd11;
            start   = 1'b1;
            @(posedge clk);
            repeat (4) begin @(negedge clk); start = 1'b0; end
            rst = 1'b0;
            @(negedge clk);
            chk("abort busy", int'(busy), 0);
            chk("abort done", int'(done), 0);
            chk("abort lps_we", int'(lps_we), 0);
            rst = 1'b1;
            dn = 0;
            repeat (50) begin @(negedge clk); if (done || busy) dn++; end
            chk("abort quiet", dn, 0);
            for (int k = 0; k < 16; k++)
                exp_t[k] = (k < v[0].tab.len()) ? int'(v[0].tab[k]) - 48 : 0;
            run("rebuild", v[0].p, v[0].m, v[0].dcyc, 1'b0, 1'b0);
        end

        // Random patterns over a small alphabet to force fallbacks
        for (int r = 0; r < 12; r++) begin
            string p;
            int m;
            m = $urandom_range(1, 16);
            p = "";
            for (int k = 0; k < m; k++) p = {p, string'(8'(8'h41 + $urandom_range(0, 2)))};
            ref_lps(p);
            for (int k = 0; k < 16; k++) exp_t[k] = mdl_t[k];
            run($sformatf("rnd%0d_%s", r, p), p, m, 2 + 3 * (m - 1) + 4 * mdl_f, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
